// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the register-file write port between the load-return
// path (priority) and a small FIFO of ALU results, with a bounded load run.
module wb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int ALU_DEPTH    = 2,
   parameter int MAX_LOAD_RUN = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             alu_valid,
   output logic                             alu_ready,
   input  logic [ADDR_W-1:0]                alu_waddr,
   input  logic [DATA_W-1:0]                alu_wdata,
   input  logic                             ld_valid,
   output logic                             ld_ready,
   input  logic [ADDR_W-1:0]                ld_waddr,
   input  logic [DATA_W-1:0]                ld_wdata,
   output logic                             rf_we,
   output logic [ADDR_W-1:0]                rf_waddr,
   output logic [DATA_W-1:0]                rf_wdata,
   output logic                             wd_sel,
   output logic [$clog2(ALU_DEPTH+1)-1:0]   alu_count
);

   localparam int CNT_W = $clog2(ALU_DEPTH + 1);
   localparam int PTR_W = (ALU_DEPTH > 1) ? $clog2(ALU_DEPTH) : 1;
   localparam int RUN_W = $clog2(MAX_LOAD_RUN + 1);
   localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(ALU_DEPTH);
   localparam logic [RUN_W-1:0] RUN_MAX_C  = RUN_W'(MAX_LOAD_RUN);
   localparam logic [PTR_W-1:0] PTR_LAST_C = PTR_W'(ALU_DEPTH - 1);

   logic [ADDR_W-1:0] fifo_addr_q [ALU_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [ALU_DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              sel_q, sel_d;

   logic fifo_empty;
   logic push;
   logic ld_grant;
   logic alu_grant;

   // Readies depend only on registered state, so there is no valid->ready path.
   always_comb begin
      fifo_empty = (count_q == '0);
      alu_ready  = (count_q != FULL_C);
      ld_ready   = !(!fifo_empty && (run_q == RUN_MAX_C));
      ld_grant   = ld_valid && ld_ready;
      alu_grant  = !ld_grant && !fifo_empty;
      push       = alu_valid && alu_ready;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      run_d    = '0;
      we_d     = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      sel_d    = sel_q;

      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST_C) ? '0 : wr_ptr_q + 1'b1;
      end
      if (alu_grant) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST_C) ? '0 : rd_ptr_q + 1'b1;
      end

      case ({push, alu_grant})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // The run only accumulates while ALU work is waiting; every other case clears it.
      if (ld_grant && !fifo_empty) begin
         run_d = (run_q == RUN_MAX_C) ? run_q : run_q + 1'b1;
      end

      if (ld_grant) begin
         we_d    = (ld_waddr != '0);
         waddr_d = ld_waddr;
         wdata_d = ld_wdata;
         sel_d   = 1'b1;
      end else if (alu_grant) begin
         we_d    = (fifo_addr_q[rd_ptr_q] != '0);
         waddr_d = fifo_addr_q[rd_ptr_q];
         wdata_d = fifo_data_q[rd_ptr_q];
         sel_d   = 1'b0;
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= alu_waddr;
         fifo_data_q[wr_ptr_q] <= alu_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         run_q    <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         sel_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         run_q    <= run_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         sel_q    <= sel_d;
      end
   end

   assign rf_we     = we_q;
   assign rf_waddr  = waddr_q;
   assign rf_wdata  = wdata_q;
   assign wd_sel    = sel_q;
   assign alu_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then random traffic, all checked
// against a queue-based model of the write-back arbitration rules.
module tb_wb_arbiter;

   localparam int DW     = 32;
   localparam int AW     = 5;
   localparam int DEPTH  = 2;
   localparam int MAXRUN = 4;
   localparam int CW     = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          alu_valid = 1'b0;
   logic          alu_ready;
   logic [AW-1:0] alu_waddr = '0;
   logic [DW-1:0] alu_wdata = '0;
   logic          ld_valid = 1'b0;
   logic          ld_ready;
   logic [AW-1:0] ld_waddr = '0;
   logic [DW-1:0] ld_wdata = '0;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          wd_sel;
   logic [CW-1:0] alu_count;

   wb_arbiter #(
      .DATA_W(DW), .ADDR_W(AW), .ALU_DEPTH(DEPTH), .MAX_LOAD_RUN(MAXRUN)
   ) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
      .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .wd_sel(wd_sel), .alu_count(alu_count)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   // Reference model: pending ALU results, current load run, expected outputs.
   ent_t          mq[$];
   int            m_run = 0;
   logic          e_we = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_data = '0;
   logic          e_sel = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      m_run  = 0;
      e_we   = 1'b0;
      e_addr = '0;
      e_data = '0;
      e_sel  = 1'b0;
   endtask

   task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd);
      alu_valid = av; alu_waddr = aa; alu_wdata = ad;
      ld_valid  = lv; ld_waddr  = la; ld_wdata  = ldd;
   endtask

   // One clock: predict from the rules, advance the clock, compare everything.
   task automatic step();
      bit   ldr, alur, ldg, psh;
      ent_t e;
      ldr  = !(mq.size() != 0 && m_run == MAXRUN);
      alur = (mq.size() < DEPTH);
      check("ld_ready", ld_ready, ldr);
      check("alu_ready", alu_ready, alur);
      ldg = ld_valid && ldr;
      psh = alu_valid && alur;
      if (ldg) begin
         e_we   = (ld_waddr != 0);
         e_addr = ld_waddr;
         e_data = ld_wdata;
         e_sel  = 1'b1;
         m_run  = (mq.size() != 0) ? ((m_run < MAXRUN) ? m_run + 1 : MAXRUN) : 0;
      end else if (mq.size() != 0) begin
         e      = mq.pop_front();
         e_we   = (e.a != 0);
         e_addr = e.a;
         e_data = e.d;
         e_sel  = 1'b0;
         m_run  = 0;
      end else begin
         e_we  = 1'b0;
         m_run = 0;
      end
      if (psh) mq.push_back('{a: alu_waddr, d: alu_wdata});
      @(posedge clk);
      #1;
      check("rf_we", rf_we, e_we);
      check("rf_waddr", rf_waddr, e_addr);
      check("rf_wdata", rf_wdata, e_data);
      check("wd_sel", wd_sel, e_sel);
      check("alu_count", alu_count, mq.size());
   endtask

   initial begin
      // Reset held with both requesters active: nothing may be written.
      rst = 1'b1;
      drive(1'b1, 5'd2, 32'h1111_0002, 1'b1, 5'd7, 32'h7777_0007);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst_we", rf_we, 1'b0);
         check("rst_waddr", rf_waddr, 0);
         check("rst_wdata", rf_wdata, 0);
         check("rst_sel", wd_sel, 1'b0);
         check("rst_count", alu_count, 0);
         check("rst_alu_ready", alu_ready, 1'b1);
         check("rst_ld_ready", ld_ready, 1'b1);
      end
      rst = 1'b0;
      model_reset();
      step();
      check("first_grant_is_load", wd_sel, 1'b1);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      repeat (2) step();

      // Single ALU result: two-edge latency.
      drive(1'b1, 5'd3, 32'h0000_00AA, 1'b0, 5'd0, 32'h0);
      step();
      check("alu_not_bypassed", rf_we, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      step();
      check("single_alu_addr", rf_waddr, 5'd3);
      check("single_alu_data", rf_wdata, 32'h0000_00AA);
      step();

      // Contention: continuous loads with two buffered ALU results.
      drive(1'b1, 5'd4, 32'h0000_0404, 1'b1, 5'd8, 32'h0000_0808);
      step();
      drive(1'b1, 5'd5, 32'h0000_0505, 1'b1, 5'd8, 32'h0000_0809);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h0000_080A);
      repeat (12) step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      repeat (2) step();

      // Full FIFO: ALU offered every cycle behind a continuous load stream.
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, AW'(10 + i), DW'(32'hA000_0000 + i), 1'b1, 5'd9, DW'(32'h9000_0000 + i));
         step();
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      repeat (4) step();

      // Register 0 load: handshake completes, no write.
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD_BEEF);
      step();
      check("reg0_no_write", rf_we, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      step();

      // Asynchronous reset with two ALU results buffered.
      drive(1'b1, 5'd10, 32'h0000_0A0A, 1'b1, 5'd9, 32'h0000_0909);
      step();
      drive(1'b1, 5'd11, 32'h0000_0B0B, 1'b1, 5'd9, 32'h0000_090A);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_090B);
      check("pre_rst_count", alu_count, 2);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_count", alu_count, 0);
      check("async_rst_we", rf_we, 1'b0);
      check("async_rst_waddr", rf_waddr, 0);
      model_reset();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) step();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic          av, lv;
         logic [AW-1:0] aa, la;
         av = ($urandom_range(0, 99) < 50);
         lv = ($urandom_range(0, 99) < 65);
         aa = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
         la = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
         drive(av, aa, DW'($urandom), lv, la, DW'($urandom));
         step();
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      repeat (4) step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
